// File: rtl/lift_pingpong_wrapper.sv
// rtl/lift_pingpong_wrapper.sv - ping-pong input/output bank wrapper around a residue lift/reduce engine
// Optional engine watchdog: define LIFT_PINGPONG_TIMEOUT_EN (parameter TIMEOUT).

module lift_pingpong_wrapper #(
   parameter int NCH   = 8,
   parameter int WW    = 30,
   parameter int DEPTH = 64,
`ifdef LIFT_PINGPONG_TIMEOUT_EN
   parameter int TIMEOUT = 4096,
`endif
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(NCH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_we,
   input  logic [AW-1:0]     in_addr,
   input  logic [NCH*WW-1:0] in_din,
   input  logic              in_commit,
   input  logic              data_type,
   input  logic              reduction_type,
   output logic              in_ready,
   output logic              eng_start,
   output logic              eng_data_type,
   output logic              eng_reduction_type,
   input  logic [AW-1:0]     eng_rd_addr,
   input  logic [CW-1:0]     eng_rd_sel,
   output logic [WW-1:0]     eng_rd_data,
   input  logic              eng_wr_en,
   input  logic [AW-1:0]     eng_wr_addr,
   input  logic [CW-1:0]     eng_wr_index,
   input  logic [WW-1:0]     eng_wr_data,
   input  logic              eng_done,
   input  logic [AW-1:0]     out_addr,
   output logic [NCH*WW-1:0] out_data,
   output logic              out_valid,
   input  logic              out_release,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_FINISH} state_t;

   state_t            r_state;
   logic [1:0]        r_ib_full;
   logic [1:0]        r_ob_full;
   logic [1:0]        r_ib_dt;
   logic [1:0]        r_ib_rt;
   logic              r_wp;
   logic              r_rp;
   logic              r_ep;
   logic              r_hp;
   logic              r_err;
   logic              r_in_ready;
   logic              r_eng_start;
   logic              r_done;
   logic              r_eng_dt;
   logic              r_eng_rt;
   logic [WW-1:0]     r_rd_data;
   logic [NCH*WW-1:0] r_out_data;

   logic [WW-1:0]     r_ib [2][DEPTH][NCH];
   logic [WW-1:0]     r_ob [2][DEPTH][NCH];

   logic              w_in_full;
   logic              w_we_ok;
   logic              w_commit_ok;
   logic              w_rel_ok;
   logic              w_run;
   logic              w_fin;
   logic              w_to;
   logic [1:0]        w_ib_full_nxt;
   logic [1:0]        w_ob_full_nxt;
   logic              w_wp_nxt;
   logic              w_rp_nxt;
   logic              w_ep_nxt;
   logic              w_hp_nxt;
   logic              w_err_nxt;

   assign w_in_full   = r_ib_full[r_wp];
   assign w_we_ok     = in_we & ~w_in_full;
   assign w_commit_ok = in_commit & ~w_in_full;
   assign w_rel_ok    = out_release & r_ob_full[r_hp];
   assign w_run       = (r_state == S_RUN);
   assign w_fin       = (r_state == S_FINISH);

`ifdef LIFT_PINGPONG_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] r_to_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_to_cnt <= '0;
      end else if (w_run) begin
         r_to_cnt <= r_to_cnt + TW'(1);
      end else begin
         r_to_cnt <= '0;
      end
   end

   // Fires on the TIMEOUT-th RUN cycle unless the engine finishes in that same cycle.
   assign w_to = w_run & ~eng_done & (r_to_cnt == TW'(TIMEOUT - 1));
`else
   assign w_to = 1'b0;
`endif

   // Commit/FINISH and FINISH/release always target different banks, so all updates merge.
   always_comb begin
      w_ib_full_nxt = r_ib_full;
      w_ob_full_nxt = r_ob_full;
      if (w_commit_ok)   w_ib_full_nxt[r_wp] = 1'b1;
      if (w_fin || w_to) w_ib_full_nxt[r_rp] = 1'b0;
      if (w_fin)         w_ob_full_nxt[r_ep] = 1'b1;
      if (w_rel_ok)      w_ob_full_nxt[r_hp] = 1'b0;
      w_wp_nxt  = r_wp ^ w_commit_ok;
      w_rp_nxt  = r_rp ^ (w_fin | w_to);
      w_ep_nxt  = r_ep ^ w_fin;
      w_hp_nxt  = r_hp ^ w_rel_ok;
      w_err_nxt = r_err | (in_we & w_in_full) | (in_commit & w_in_full)
                | (eng_wr_en & ~w_run) | w_to;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ib_full  <= 2'b00;
         r_ob_full  <= 2'b00;
         r_ib_dt    <= 2'b00;
         r_ib_rt    <= 2'b00;
         r_wp       <= 1'b0;
         r_rp       <= 1'b0;
         r_ep       <= 1'b0;
         r_hp       <= 1'b0;
         r_err      <= 1'b0;
         r_in_ready <= 1'b0;
      end else begin
         r_ib_full  <= w_ib_full_nxt;
         r_ob_full  <= w_ob_full_nxt;
         r_wp       <= w_wp_nxt;
         r_rp       <= w_rp_nxt;
         r_ep       <= w_ep_nxt;
         r_hp       <= w_hp_nxt;
         r_err      <= w_err_nxt;
         r_in_ready <= ~w_ib_full_nxt[w_wp_nxt];
         if (w_commit_ok) begin
            r_ib_dt[r_wp] <= data_type;
            r_ib_rt[r_wp] <= reduction_type;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_eng_start <= 1'b0;
         r_done      <= 1'b0;
         r_eng_dt    <= 1'b0;
         r_eng_rt    <= 1'b0;
      end else begin
         r_eng_start <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_ib_full[r_rp] && !r_ob_full[r_ep]) begin
                  r_state     <= S_START;
                  r_eng_start <= 1'b1;
                  r_eng_dt    <= r_ib_dt[r_rp];
                  r_eng_rt    <= r_ib_rt[r_rp];
               end
            end
            S_START: r_state <= S_RUN;
            S_RUN: begin
               if (eng_done) begin
                  r_state <= S_FINISH;
                  r_done  <= 1'b1;
               end else if (w_to) begin
                  r_state <= S_IDLE;
               end
            end
            S_FINISH: r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_we_ok) begin
         for (int k = 0; k < NCH; k++) begin
            r_ib[r_wp][in_addr][k] <= in_din[k*WW +: WW];
         end
      end
      if (eng_wr_en && w_run) begin
         r_ob[r_ep][eng_wr_addr][eng_wr_index] <= eng_wr_data;
      end
      r_rd_data <= r_ib[r_rp][eng_rd_addr][eng_rd_sel];
      for (int k = 0; k < NCH; k++) begin
         r_out_data[k*WW +: WW] <= r_ob[r_hp][out_addr][k];
      end
   end

   assign in_ready           = r_in_ready;
   assign eng_start          = r_eng_start;
   assign eng_data_type      = r_eng_dt;
   assign eng_reduction_type = r_eng_rt;
   assign eng_rd_data        = r_rd_data;
   assign out_data           = r_out_data;
   assign out_valid          = r_ob_full[r_hp];
   assign done               = r_done;
   assign err                = r_err;

endmodule

// File: tb/tb_lift_pingpong_wrapper.sv
// tb/tb_lift_pingpong_wrapper.sv - directed self-checking bench for lift_pingpong_wrapper

module tb_lift_pingpong_wrapper;

   localparam int NCH   = 8;
   localparam int WW    = 30;
   localparam int DEPTH = 64;
   localparam int AW    = 6;
   localparam int CW    = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_we = 1'b0;
   logic [AW-1:0]     in_addr = '0;
   logic [NCH*WW-1:0] in_din = '0;
   logic              in_commit = 1'b0;
   logic              data_type = 1'b0;
   logic              reduction_type = 1'b0;
   logic [AW-1:0]     eng_rd_addr = '0;
   logic [CW-1:0]     eng_rd_sel = '0;
   logic              eng_wr_en = 1'b0;
   logic [AW-1:0]     eng_wr_addr = '0;
   logic [CW-1:0]     eng_wr_index = '0;
   logic [WW-1:0]     eng_wr_data = '0;
   logic              eng_done = 1'b0;
   logic [AW-1:0]     out_addr = '0;
   logic              out_release = 1'b0;

   logic              in_ready;
   logic              eng_start;
   logic              eng_data_type;
   logic              eng_reduction_type;
   logic [WW-1:0]     eng_rd_data;
   logic [NCH*WW-1:0] out_data;
   logic              out_valid;
   logic              done;
   logic              err;

   int n_cmp = 0;
   int n_bad = 0;
   int start_cnt = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   lift_pingpong_wrapper #(.NCH(NCH), .WW(WW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_we(in_we), .in_addr(in_addr), .in_din(in_din),
      .in_commit(in_commit), .data_type(data_type), .reduction_type(reduction_type),
      .in_ready(in_ready), .eng_start(eng_start), .eng_data_type(eng_data_type),
      .eng_reduction_type(eng_reduction_type), .eng_rd_addr(eng_rd_addr),
      .eng_rd_sel(eng_rd_sel), .eng_rd_data(eng_rd_data), .eng_wr_en(eng_wr_en),
      .eng_wr_addr(eng_wr_addr), .eng_wr_index(eng_wr_index), .eng_wr_data(eng_wr_data),
      .eng_done(eng_done), .out_addr(out_addr), .out_data(out_data),
      .out_valid(out_valid), .out_release(out_release), .done(done), .err(err)
   );

`ifdef LIFT_PINGPONG_TIMEOUT_EN
   logic              t_in_ready;
   logic              t_eng_start;
   logic              t_eng_dt;
   logic              t_eng_rt;
   logic [WW-1:0]     t_eng_rd_data;
   logic [NCH*WW-1:0] t_out_data;
   logic              t_out_valid;
   logic              t_done;
   logic              t_err;

   lift_pingpong_wrapper #(.NCH(NCH), .WW(WW), .DEPTH(DEPTH), .TIMEOUT(16)) dut_to (
      .clk(clk), .rst(rst), .in_we(in_we), .in_addr(in_addr), .in_din(in_din),
      .in_commit(in_commit), .data_type(data_type), .reduction_type(reduction_type),
      .in_ready(t_in_ready), .eng_start(t_eng_start), .eng_data_type(t_eng_dt),
      .eng_reduction_type(t_eng_rt), .eng_rd_addr(eng_rd_addr),
      .eng_rd_sel(eng_rd_sel), .eng_rd_data(t_eng_rd_data), .eng_wr_en(eng_wr_en),
      .eng_wr_addr(eng_wr_addr), .eng_wr_index(eng_wr_index), .eng_wr_data(eng_wr_data),
      .eng_done(eng_done), .out_addr(out_addr), .out_data(t_out_data),
      .out_valid(t_out_valid), .out_release(out_release), .done(t_done), .err(t_err)
   );
`endif

   always @(posedge clk) begin
      if (eng_start === 1'b1) start_cnt <= start_cnt + 1;
      if (done === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_we = 0; in_commit = 0; eng_wr_en = 0; eng_done = 0; out_release = 0;
      rst = 0;
      tick();
      tick();
      rst = 1;
      tick();
   endtask

   function automatic logic [WW-1:0] word(input int b, input int r, input int k);
      if (b == 0) return WW'(32'h100 + k);
      return WW'((b << 16) | (r << 4) | k);
   endfunction

   task automatic write_block(input int b, input int nr);
      for (int r = 0; r < nr; r++) begin
         in_we   = 1;
         in_addr = AW'(r);
         for (int k = 0; k < NCH; k++) in_din[k*WW +: WW] = word(b, r, k);
         tick();
      end
      in_we = 0;
   endtask

   task automatic commit(input logic dt, input logic rt);
      in_commit = 1; data_type = dt; reduction_type = rt;
      tick();
      in_commit = 0;
   endtask

   task automatic wait_start(output bit ok);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (eng_start === 1'b1) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic echo(input int r0, input int nr, input int nk);
      for (int r = r0; r < r0 + nr; r++) begin
         for (int k = 0; k < nk; k++) begin
            eng_rd_addr = AW'(r);
            eng_rd_sel  = CW'(k);
            tick();
            eng_wr_en    = 1;
            eng_wr_addr  = AW'(r);
            eng_wr_index = CW'(k);
            eng_wr_data  = eng_rd_data;
            tick();
            eng_wr_en = 0;
         end
      end
   endtask

   task automatic finish_block();
      eng_done = 1;
      tick();
      eng_done = 0;
      tick();
   endtask

   task automatic test_reset();
      rst = 0;
      #12;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (eng_start !== 1'b0) begin n_bad++; $display("FAIL reset_eng_start: got %b want 0", eng_start); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
      rst = 1;
      tick();
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_basic_lift();
      bit ok;
      int bd;
      logic [WW-1:0] v;
      do_reset();
      bd = done_cnt;
      write_block(0, DEPTH);
      commit(1, 0);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
      wait_start(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_start: got no eng_start want one within 20 cycles"); end
      n_cmp++; if (eng_data_type !== 1'b1) begin n_bad++; $display("FAIL basic_data_type: got %b want 1", eng_data_type); end
      eng_rd_addr = 5; eng_rd_sel = 3;
      tick();
      n_cmp++; if (eng_start !== 1'b0) begin n_bad++; $display("FAIL basic_start_width: got %b want 0", eng_start); end
      n_cmp++; if (eng_rd_data !== 30'h103) begin n_bad++; $display("FAIL basic_rd_data: got %h want 103", eng_rd_data); end
      echo(0, DEPTH, NCH);
      eng_done = 1;
      tick();
      eng_done = 0;
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL basic_done_pulse: got %b want 1", done); end
      tick();
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width: got %b want 0", done); end
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
      out_addr = 5;
      tick();
      v = out_data[3*WW +: WW];
      n_cmp++; if (v !== 30'h103) begin n_bad++; $display("FAIL basic_out_data: got %h want 103", v); end
      n_cmp++; if (done_cnt - bd !== 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - bd); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b want 0", err); end
      out_release = 1;
      tick();
      out_release = 0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_release: got %b want 0", out_valid); end
   endtask

   task automatic test_pingpong();
      bit ok;
      int bs, bd;
      logic [WW-1:0] v;
      do_reset();
      bs = start_cnt; bd = done_cnt;
      write_block(2, 4);
      commit(0, 1);
      write_block(3, 4);
      commit(1, 0);
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL pp_in_ready_full: got %b want 0", in_ready); end
      commit(1, 1);
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL pp_third_commit_err: got %b want 1", err); end
      tick();
      n_cmp++; if (start_cnt - bs !== 1) begin n_bad++; $display("FAIL pp_first_start: got %0d want 1", start_cnt - bs); end
      n_cmp++; if ({eng_data_type, eng_reduction_type} !== 2'b01) begin n_bad++; $display("FAIL pp_a_types: got %b want 01", {eng_data_type, eng_reduction_type}); end
      echo(0, 4, 2);
      finish_block();
      n_cmp++; if (done_cnt - bd !== 1) begin n_bad++; $display("FAIL pp_a_done: got %0d want 1", done_cnt - bd); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL pp_in_ready_free: got %b want 1", in_ready); end
      wait_start(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL pp_b_start: got no eng_start want one within 20 cycles"); end
      n_cmp++; if ({eng_data_type, eng_reduction_type} !== 2'b10) begin n_bad++; $display("FAIL pp_b_types: got %b want 10", {eng_data_type, eng_reduction_type}); end
      tick();
      echo(0, 4, 2);
      finish_block();
      n_cmp++; if (done_cnt - bd !== 2) begin n_bad++; $display("FAIL pp_b_done: got %0d want 2", done_cnt - bd); end
      out_addr = 2;
      tick();
      v = out_data[1*WW +: WW];
      n_cmp++; if (v !== 30'h20021) begin n_bad++; $display("FAIL pp_a_out: got %h want 20021", v); end
      out_release = 1;
      tick();
      out_release = 0;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL pp_b_valid: got %b want 1", out_valid); end
      out_addr = 3;
      tick();
      v = out_data[0 +: WW];
      n_cmp++; if (v !== 30'h30030) begin n_bad++; $display("FAIL pp_b_out: got %h want 30030", v); end
   endtask

   task automatic test_throughput();
      bit ok;
      int cnt;
      do_reset();
      write_block(4, 1);
      commit(0, 0);
      write_block(5, 1);
      commit(0, 0);
      tick();
      finish_block();
      wait_start(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL tp_start: got no eng_start want one within 20 cycles"); end
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         in_we = (i == 0); in_addr = 0;
         in_commit = (i == 1);
         out_release = (i == 2);
         tick();
         cnt++;
      end
      in_we = 0; in_commit = 0; out_release = 0;
      eng_done = 1;
      tick();
      cnt++;
      eng_done = 0;
      while (eng_start !== 1'b1 && cnt < 20) begin
         tick();
         cnt++;
      end
      n_cmp++; if (cnt !== 8) begin n_bad++; $display("FAIL tp_start_to_start: got %0d want 8", cnt); end
   endtask

   task automatic test_backpressure();
      bit ok;
      int bs;
      do_reset();
      for (int b = 0; b < 2; b++) begin
         commit(0, 0);
         wait_start(ok);
         n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_start_%0d: got no eng_start want one within 20 cycles", b); end
         tick();
         finish_block();
      end
      commit(1, 0);
      bs = start_cnt;
      repeat (10) tick();
      n_cmp++; if (start_cnt - bs !== 0) begin n_bad++; $display("FAIL bp_stalled: got %0d starts want 0", start_cnt - bs); end
      n_cmp++; if (eng_start !== 1'b0) begin n_bad++; $display("FAIL bp_eng_start_low: got %b want 0", eng_start); end
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
      out_release = 1;
      tick();
      out_release = 0;
      repeat (10) tick();
      n_cmp++; if (start_cnt - bs !== 1) begin n_bad++; $display("FAIL bp_resume: got %0d starts want 1", start_cnt - bs); end
   endtask

   task automatic test_simultaneous();
      bit ok;
      int bd;
      logic [WW-1:0] v;
      do_reset();
      write_block(8, 1);
      commit(0, 0);
      wait_start(ok);
      tick();
      echo(0, 1, 2);
      finish_block();
      write_block(9, 1);
      commit(0, 0);
      wait_start(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL sim_start9: got no eng_start want one within 20 cycles"); end
      tick();
      echo(0, 1, 2);
      write_block(10, 1);
      bd = done_cnt;
      eng_done = 1;
      tick();
      eng_done = 0;
      in_commit = 1; data_type = 1; reduction_type = 1;
      out_release = 1;
      tick();
      in_commit = 0; out_release = 0;
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL sim_err: got %b want 0", err); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL sim_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL sim_out_valid: got %b want 1", out_valid); end
      n_cmp++; if (done_cnt - bd !== 1) begin n_bad++; $display("FAIL sim_done: got %0d want 1", done_cnt - bd); end
      wait_start(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL sim_start10: got no eng_start want one within 20 cycles"); end
      n_cmp++; if ({eng_data_type, eng_reduction_type} !== 2'b11) begin n_bad++; $display("FAIL sim_types10: got %b want 11", {eng_data_type, eng_reduction_type}); end
      out_addr = 0;
      tick();
      v = out_data[1*WW +: WW];
      n_cmp++; if (v !== 30'h90001) begin n_bad++; $display("FAIL sim_out9: got %h want 90001", v); end
      echo(0, 1, 2);
      finish_block();
      out_release = 1;
      tick();
      out_release = 0;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL sim_valid10: got %b want 1", out_valid); end
      tick();
      v = out_data[0 +: WW];
      n_cmp++; if (v !== 30'hA0000) begin n_bad++; $display("FAIL sim_out10: got %h want a0000", v); end
   endtask

   task automatic test_reset_mid_run();
      bit ok;
      int bs, bd;
      do_reset();
      commit(0, 0);
      wait_start(ok);
      tick();
      finish_block();
      commit(0, 0);
      wait_start(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmr_start: got no eng_start want one within 20 cycles"); end
      bs = start_cnt + 1; bd = done_cnt;
      repeat (10) tick();
      rst = 0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmr_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rmr_done: got %b want 0", done); end
      tick();
      rst = 1;
      tick();
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmr_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rmr_err: got %b want 0", err); end
      repeat (5) tick();
      n_cmp++; if (done_cnt - bd !== 0) begin n_bad++; $display("FAIL rmr_no_done: got %0d want 0", done_cnt - bd); end
      n_cmp++; if (start_cnt - bs !== 0) begin n_bad++; $display("FAIL rmr_no_start: got %0d want 0", start_cnt - bs); end
   endtask

   task automatic test_errors();
      int bs, bd;
      do_reset();
      bs = start_cnt; bd = done_cnt;
      out_release = 1;
      tick();
      out_release = 0;
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_idle_release: got %b want 0", err); end
      eng_done = 1;
      tick();
      tick();
      eng_done = 0;
      tick();
      n_cmp++; if (done_cnt - bd !== 0) begin n_bad++; $display("FAIL err_idle_done: got %0d want 0", done_cnt - bd); end
      n_cmp++; if (start_cnt - bs !== 0) begin n_bad++; $display("FAIL err_idle_start: got %0d want 0", start_cnt - bs); end
      eng_wr_en = 1;
      tick();
      eng_wr_en = 0;
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_wr_outside_run: got %b want 1", err); end
      do_reset();
      commit(0, 0);
      commit(0, 0);
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_two_commits: got %b want 0", err); end
      in_we = 1;
      tick();
      in_we = 0;
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_write_full: got %b want 1", err); end
   endtask

`ifdef LIFT_PINGPONG_TIMEOUT_EN
   task automatic test_timeout();
      bit seen_done;
      do_reset();
      seen_done = 0;
      write_block(13, 1);
      commit(0, 0);
      write_block(14, 1);
      commit(0, 0);
      n_cmp++; if (t_in_ready !== 1'b0) begin n_bad++; $display("FAIL to_in_ready_full: got %b want 0", t_in_ready); end
      repeat (15) begin
         tick();
         if (t_done === 1'b1) seen_done = 1;
      end
      n_cmp++; if (t_err !== 1'b0) begin n_bad++; $display("FAIL to_err_early: got %b want 0", t_err); end
      tick();
      n_cmp++; if (t_err !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b want 1", t_err); end
      n_cmp++; if (t_in_ready !== 1'b1) begin n_bad++; $display("FAIL to_in_ready: got %b want 1", t_in_ready); end
      n_cmp++; if (t_out_valid !== 1'b0) begin n_bad++; $display("FAIL to_out_valid: got %b want 0", t_out_valid); end
      n_cmp++; if (seen_done || t_done !== 1'b0) begin n_bad++; $display("FAIL to_no_done: got %b want 0", seen_done | t_done); end
      tick();
      n_cmp++; if (t_eng_start !== 1'b1) begin n_bad++; $display("FAIL to_next_start: got %b want 1", t_eng_start); end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic_lift();
      test_pingpong();
      test_throughput();
      test_backpressure();
      test_simultaneous();
      test_reset_mid_run();
      test_errors();
`ifdef LIFT_PINGPONG_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lift_pingpong_wrapper.md
LIFT_PINGPONG_WRAPPER -- requirements
Module: lift_pingpong_wrapper

Interface
REQ-001 Parameter NCH, default 8: residue channels (cores) per row.
REQ-002 Parameter WW, default 30: residue word width in bits.
REQ-003 Parameter DEPTH, default 64: rows per buffer bank. AW = clog2(DEPTH), CW = clog2(NCH), both derived locally.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset. The ports are:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_we  in  1  host row write strobe.
- in_addr  in  AW  host write row.
- in_din  in  NCH*WW  host row; channel k occupies bits [k*WW +: WW].
- in_commit  in  1  one-cycle pulse; marks the host-write input bank full.
- data_type  in  1  1 = lift q->Q, 0 = reduce; sampled at in_commit.
- reduction_type  in  1  sampled at in_commit.
- in_ready  out  1  host-write input bank free.
- eng_start  out  1  one-cycle engine start pulse.
- eng_data_type  out  1  stored data_type of the bank being processed.
- eng_reduction_type  out  1  stored reduction_type of the bank being processed.
- eng_rd_addr  in  AW  engine read row.
- eng_rd_sel  in  CW  engine read channel.
- eng_rd_data  out  WW  engine read word; 1-cycle latency.
- eng_wr_en  in  1  engine result write strobe.
- eng_wr_addr  in  AW  engine result row.
- eng_wr_index  in  CW  engine result channel.
- eng_wr_data  in  WW  engine result word.
- eng_done  in  1  engine finished the current block.
- out_addr  in  AW  host read row.
- out_data  out  NCH*WW  host read row; 1-cycle latency.
- out_valid  out  1  host-read output bank full.
- out_release  in  1  one-cycle pulse; frees the host-read output bank.
- done  out  1  one-cycle pulse per completed block.
- err  out  1  sticky error flag.

Function
REQ-005 Input buffering: two input banks IB0/IB1 with a host write pointer wp and an engine read pointer rp. Output buffering: two output banks OB0/OB1 with an engine write pointer ep and a host read pointer hp. Each bank has a full flag.
REQ-006 Host input writes: in_we with IB[wp] not full SHALL write in_din to row in_addr. in_we with IB[wp] full SHALL be ignored and SHALL set err.
REQ-007 Commit: in_commit with IB[wp] not full SHALL set that bank's full flag, store data_type and reduction_type with the bank, and toggle wp. in_commit with IB[wp] full SHALL be ignored and SHALL set err.
REQ-008 in_ready SHALL equal !full(IB[wp]), registered.
REQ-009 Engine FSM states are IDLE, START, RUN, FINISH.
- IDLE->START when IB[rp] is full and OB[ep] is not full.
- START asserts eng_start for exactly one cycle, then goes to RUN.
- RUN->FINISH on eng_done.
- FINISH clears full(IB[rp]), sets full(OB[ep]), toggles rp and ep, pulses done, then goes to IDLE.
REQ-010 eng_data_type and eng_reduction_type SHALL hold the values stored for IB[rp] from START through FINISH.
REQ-011 eng_rd_data SHALL return word eng_rd_sel of row eng_rd_addr of IB[rp] one cycle after the address is presented.
REQ-012 Engine result writes: eng_wr_en SHALL write eng_wr_data into channel eng_wr_index, row eng_wr_addr of OB[ep], and SHALL be honoured only in RUN. eng_wr_en outside RUN SHALL be dropped and SHALL set err.
REQ-013 eng_done outside RUN SHALL be ignored.
REQ-014 Host output reads: out_valid = full(OB[hp]). out_data SHALL return row out_addr of OB[hp] one cycle later; contents are undefined when out_valid is 0.
REQ-015 out_release with out_valid high SHALL clear full(OB[hp]) and toggle hp. out_release with out_valid low SHALL be ignored and SHALL not set err.
REQ-016 Simultaneous events: a FINISH flag update, in_commit and out_release in the same cycle SHALL all take effect, because each touches a distinct flag or pointer.
REQ-017 Bounds:
- Start-to-start throughput SHALL be the engine time plus 3 cycles.
- At most 2 blocks SHALL be pending per side.
- Pointers SHALL wrap 1->0.

Reset
REQ-018 rst low SHALL immediately force:
- FSM to IDLE;
- all full flags, wp, rp, ep, hp and err to 0;
- eng_start, done and out_valid to 0;
- in_ready to 1 on the first clock after release.
RAM contents are not reset.
REQ-019 Reset asserted in RUN SHALL abandon the block with no done pulse. The engine is reset by the same rst.

Configuration
REQ-020 Macro LIFT_PINGPONG_TIMEOUT_EN controls an engine watchdog, with parameter TIMEOUT, default 4096.
- Defined: a counter SHALL run in RUN. Reaching TIMEOUT without eng_done SHALL set err, free IB[rp] and toggle rp, leave OB[ep] not full, emit no done pulse, and return to IDLE.
- Undefined: no counter exists and RUN waits indefinitely.

Verification
REQ-021 Basic lift: write 64 rows with channel k = 30'h0000_0100 + k, commit with data_type = 1. The engine model echoes each word.
- Expected: eng_start one cycle after entering START, eng_data_type = 1, done pulse, out_valid = 1, and out_data row 5 channel 3 = 30'h0000_0103.
REQ-022 Ping-pong: commit two blocks back-to-back, then attempt a third commit before any engine completion.
- Expected: in_ready = 0 after the second commit; the third in_commit sets err; the first two blocks complete in order.
REQ-023 Output backpressure: complete two blocks without issuing out_release.
- Expected: a third committed block stays in IDLE with eng_start low until out_release; exactly one start follows the release.
REQ-024 Simultaneous events: in the same cycle, in_commit, FINISH and out_release.
- Expected: wp, rp, ep and hp all toggle; flags are consistent; err stays 0.
REQ-025 Reset mid-RUN: pull rst low 10 cycles after eng_start.
- Expected: out_valid = 0, in_ready = 1, err = 0, no done pulse.
REQ-026 With LIFT_PINGPONG_TIMEOUT_EN defined and TIMEOUT = 16, withhold eng_done.
- Expected: err = 1 at RUN cycle 16, FSM back in IDLE, in_ready = 1.
